// File: rtl/ibex_pkg_pext.sv
// Shared types for the packed-SIMD multiply sequencer: datapath modes, sequencer
// states and the decoded cycle-count encodings.
package ibex_pkg_pext;

  typedef enum logic [1:0] {
    M8X8   = 2'b00,
    M16X16 = 2'b01,
    M32X16 = 2'b10,
    M32X32 = 2'b11
  } mult_pext_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    S1   = 2'b01,
    S2   = 2'b10
  } mult_pext_seq_state_e;

  // Decoded op length; 2'b10 is never produced by decode and is run as CNT_2C.
  localparam logic [1:0] CNT_1C  = 2'b00;
  localparam logic [1:0] CNT_2C  = 2'b01;
  localparam logic [1:0] CNT_ILL = 2'b10;
  localparam logic [1:0] CNT_3C  = 2'b11;

  function automatic logic [1:0] stage_of(mult_pext_seq_state_e s);
    case (s)
      S1:      return 2'd1;
      S2:      return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ibex_mult_pext_seq.sv
// Sequencer for multi-cycle packed-SIMD multiplies: steps IDLE -> S1 -> S2,
// captures partial products and flags the final (optionally accumulating) cycle.
//
// state | meaning
// IDLE  | waiting; single-cycle ops complete here
// S1    | second cycle of a 2- or 3-cycle op
// S2    | third cycle of a 3-cycle op
module ibex_mult_pext_seq
  import ibex_pkg_pext::*;
#(
  parameter int IMD_W = 34
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mult_en_i,
  input  logic [1:0]       cycle_count_i,
  input  logic [1:0]       mult_mode_i,
  input  logic             accum_i,
  input  logic [IMD_W-1:0] imd_val_d_i,
  output logic [1:0]       mult_mode_o,
  output logic [1:0]       stage_o,
  output logic             imd_we_o,
  output logic [IMD_W-1:0] imd_val_q_o,
  output logic             accum_en_o,
  output logic             mult_valid_o,
  output logic             busy_o
);

  mult_pext_seq_state_e state_q, state_d;
  mult_pext_mode_e      mode_q;
  logic [1:0]           cnt_q;
  logic                 accum_q;
  logic [IMD_W-1:0]     imd_val_q;
  logic                 accept;

  assign accept      = (state_q == IDLE) && mult_en_i && !rst_i;
  assign stage_o     = stage_of(state_q);
  assign busy_o      = (state_q != IDLE);
  assign imd_val_q_o = imd_val_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_1C;
      mode_q    <= M8X8;
      accum_q   <= 1'b0;
      imd_val_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= cycle_count_i;
        mode_q  <= mult_pext_mode_e'(mult_mode_i);
        accum_q <= accum_i;
      end
      if (imd_we_o) begin
        imd_val_q <= imd_val_d_i;
      end
    end
  end

  // Strobes are suppressed while rst_i is high so a reset mid-op never
  // produces a result or a partial-product write.
  always_comb begin
    state_d      = state_q;
    mult_mode_o  = 2'b00;
    imd_we_o     = 1'b0;
    accum_en_o   = 1'b0;
    mult_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (mult_en_i) begin
          mult_mode_o = mult_mode_i;
          if (!rst_i) begin
            if (cycle_count_i == CNT_1C) begin
              mult_valid_o = 1'b1;
              accum_en_o   = accum_i;
            end else begin
              imd_we_o = 1'b1;
              state_d  = S1;
            end
          end
        end
      end
      S1: begin
        mult_mode_o = mode_q;
        if (!mult_en_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_3C) begin
          imd_we_o = !rst_i;
          state_d  = S2;
        end else begin
          mult_valid_o = !rst_i;
          accum_en_o   = accum_q && !rst_i;
          state_d      = IDLE;
        end
      end
      S2: begin
        mult_mode_o = mode_q;
        state_d     = IDLE;
        if (mult_en_i) begin
          mult_valid_o = !rst_i;
          accum_en_o   = accum_q && !rst_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ibex_mult_pext_seq.sv
// Self-checking bench for ibex_mult_pext_seq: directed scenarios with literal
// expectations plus randomized traffic against an op-level reference model.
module tb_ibex_mult_pext_seq;
  localparam int IMD_W = 34;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             mult_en_i = 1'b0;
  logic [1:0]       cycle_count_i = 2'b00;
  logic [1:0]       mult_mode_i = 2'b00;
  logic             accum_i = 1'b0;
  logic [IMD_W-1:0] imd_val_d_i = '0;
  logic [1:0]       mult_mode_o;
  logic [1:0]       stage_o;
  logic             imd_we_o;
  logic [IMD_W-1:0] imd_val_q_o;
  logic             accum_en_o;
  logic             mult_valid_o;
  logic             busy_o;

  ibex_mult_pext_seq #(.IMD_W(IMD_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .mult_en_i     (mult_en_i),
    .cycle_count_i (cycle_count_i),
    .mult_mode_i   (mult_mode_i),
    .accum_i       (accum_i),
    .imd_val_d_i   (imd_val_d_i),
    .mult_mode_o   (mult_mode_o),
    .stage_o       (stage_o),
    .imd_we_o      (imd_we_o),
    .imd_val_q_o   (imd_val_q_o),
    .accum_en_o    (accum_en_o),
    .mult_valid_o  (mult_valid_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_illegal = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Reference model: an op is a sequence of len cycles indexed k = 0..len-1;
  // partial products are written on every cycle but the last, result on the last.
  bit               m_busy = 1'b0;
  int               m_k = 0;
  int               m_len = 1;
  logic [1:0]       m_mode = 2'b00;
  logic [1:0]       m_cnt = 2'b00;
  logic             m_acc = 1'b0;
  logic [IMD_W-1:0] m_imd = '0;

  function automatic int op_len(input logic [1:0] c);
    if (c == 2'b00) return 1;
    if (c == 2'b11) return 3;
    return 2;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      int         k, len;
      logic       acc, act;
      logic [1:0] e_mode, e_stage;
      logic       e_we, e_valid, e_acc;
      act = mult_en_i && !rst_i;
      if (m_busy) begin
        k = m_k; len = m_len; acc = m_acc; e_mode = m_mode;
      end else begin
        k = 0; len = op_len(cycle_count_i); acc = accum_i;
        e_mode = mult_en_i ? mult_mode_i : 2'b00;
      end
      e_stage = m_busy ? 2'(m_k) : 2'd0;
      e_valid = act && (k == len - 1);
      e_we    = act && (k < len - 1);
      e_acc   = e_valid && acc;
      check("mode", 64'(mult_mode_o), 64'(e_mode));
      check("stage", 64'(stage_o), 64'(e_stage));
      check("imd_we", 64'(imd_we_o), 64'(e_we));
      check("imd_q", 64'(imd_val_q_o), 64'(m_imd));
      check("accum_en", 64'(accum_en_o), 64'(e_acc));
      check("valid", 64'(mult_valid_o), 64'(e_valid));
      check("busy", 64'(busy_o), 64'(m_busy));

      if (!m_busy && act && cycle_count_i == 2'b10) n_illegal++;
      illegal_len: assert (!(m_busy && act && m_cnt == 2'b10 && m_k == 1) || mult_valid_o)
        else $error("illegal count 10 op did not finish in 2 cycles");

      if (rst_i) begin
        m_busy = 1'b0; m_k = 0; m_imd = '0; m_mode = 2'b00; m_cnt = 2'b00; m_acc = 1'b0;
      end else if (!m_busy) begin
        if (mult_en_i) begin
          m_mode = mult_mode_i; m_cnt = cycle_count_i; m_acc = accum_i;
          m_len  = op_len(cycle_count_i);
          if (m_len > 1) begin
            m_imd = imd_val_d_i; m_busy = 1'b1; m_k = 1;
          end
        end
      end else if (!mult_en_i) begin
        m_busy = 1'b0; m_k = 0;
      end else if (m_k < m_len - 1) begin
        m_imd = imd_val_d_i; m_k++;
      end else begin
        m_busy = 1'b0; m_k = 0;
      end
    end
  end

  task automatic drive(input logic r, input logic en, input logic [1:0] cnt,
                       input logic [1:0] md, input logic acc, input logic [IMD_W-1:0] d);
    @(posedge clk);
    #1;
    rst_i = r; mult_en_i = en; cycle_count_i = cnt; mult_mode_i = md;
    accum_i = acc; imd_val_d_i = d;
    #1;
  endtask

  initial begin
    drive(1, 0, 2'b00, 2'b00, 0, '0);
    drive(1, 0, 2'b00, 2'b00, 0, '0);
    chk_en = 1'b1;
    drive(0, 0, 2'b00, 2'b00, 0, '0);
    check("rst_outputs", {mult_valid_o, imd_we_o, accum_en_o, busy_o, stage_o, mult_mode_o}, 64'h0);
    check("rst_imd", 64'(imd_val_q_o), 64'h0);

    // single-cycle op
    drive(0, 1, 2'b00, 2'b10, 1, 34'h3);
    check("c00_valid", 64'(mult_valid_o), 64'h1);
    check("c00_busy", 64'(busy_o), 64'h0);
    check("c00_we", 64'(imd_we_o), 64'h0);
    check("c00_mode", 64'(mult_mode_o), 64'h2);
    drive(0, 0, 2'b00, 2'b00, 0, '0);

    // three-cycle accumulating op
    drive(0, 1, 2'b11, 2'b11, 1, 34'h1);
    check("c11_we0", 64'(imd_we_o), 64'h1);
    drive(0, 1, 2'b11, 2'b11, 1, 34'h2);
    check("c11_we1", 64'(imd_we_o), 64'h1);
    check("c11_stage1", 64'(stage_o), 64'h1);
    drive(0, 1, 2'b11, 2'b11, 1, 34'h7);
    check("c11_stage2", 64'(stage_o), 64'h2);
    check("c11_imd", 64'(imd_val_q_o), 64'h2);
    check("c11_valid", 64'(mult_valid_o), 64'h1);
    check("c11_accum", 64'(accum_en_o), 64'h1);
    drive(0, 0, 2'b00, 2'b00, 0, '0);

    // inputs changed after acceptance are ignored
    drive(0, 1, 2'b01, 2'b01, 0, 34'h9);
    drive(0, 1, 2'b11, 2'b11, 1, 34'hA);
    check("hold_mode", 64'(mult_mode_o), 64'h1);
    check("hold_valid", 64'(mult_valid_o), 64'h1);
    check("hold_accum", 64'(accum_en_o), 64'h0);
    drive(0, 0, 2'b00, 2'b00, 0, '0);

    // flush in S1
    drive(0, 1, 2'b11, 2'b00, 0, 34'hA);
    drive(0, 0, 2'b11, 2'b00, 0, 34'hB);
    check("flush_valid", 64'(mult_valid_o), 64'h0);
    check("flush_we", 64'(imd_we_o), 64'h0);
    drive(0, 0, 2'b00, 2'b00, 0, 34'hC);
    check("flush_idle", 64'(busy_o), 64'h0);
    check("flush_imd", 64'(imd_val_q_o), 64'hA);

    // reset in S2
    drive(0, 1, 2'b11, 2'b00, 1, 34'h5);
    drive(0, 1, 2'b11, 2'b00, 1, 34'h6);
    drive(1, 1, 2'b11, 2'b00, 1, 34'h7);
    check("rst_s2_valid", 64'(mult_valid_o), 64'h0);
    drive(0, 0, 2'b00, 2'b00, 0, '0);
    check("rst_s2_stage", 64'(stage_o), 64'h0);
    check("rst_s2_imd", 64'(imd_val_q_o), 64'h0);
    check("rst_s2_nov", 64'(mult_valid_o), 64'h0);

    // back-to-back two-cycle ops
    drive(0, 1, 2'b01, 2'b00, 0, 34'h11);
    check("b2b_c0", 64'(mult_valid_o), 64'h0);
    drive(0, 1, 2'b01, 2'b00, 0, 34'h12);
    check("b2b_c1", 64'(mult_valid_o), 64'h1);
    drive(0, 1, 2'b01, 2'b00, 0, 34'h13);
    check("b2b_c2_valid", 64'(mult_valid_o), 64'h0);
    check("b2b_c2_we", 64'(imd_we_o), 64'h1);
    drive(0, 1, 2'b01, 2'b00, 0, 34'h14);
    check("b2b_c3", 64'(mult_valid_o), 64'h1);
    check("b2b_imd", 64'(imd_val_q_o), 64'h13);

    // illegal count runs as two cycles
    drive(0, 1, 2'b10, 2'b00, 1, 34'h21);
    drive(0, 1, 2'b10, 2'b00, 1, 34'h22);
    check("ill_valid", 64'(mult_valid_o), 64'h1);
    check("ill_stage", 64'(stage_o), 64'h1);

    for (int i = 0; i < 4000; i++) begin
      logic [IMD_W-1:0] d;
      d = {2'($urandom_range(0, 3)), 32'($urandom())};
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), d);
    end
    drive(0, 0, 2'b00, 2'b00, 0, '0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("illegal count 10 accepted %0d times", n_illegal);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ibex_mult_pext_seq.md
IBEX_MULT_PEXT_SEQ -- requirements
Module: ibex_mult_pext_seq

Interface
REQ-001 The block SHALL have parameter IMD_W, default 34, giving the intermediate-product register width.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk_i  in  1  Sole clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  Synchronous reset, active-high.
REQ-005 mult_en_i  in  1  Multiply request; held high by ID until mult_valid_o; low mid-op means flush.
REQ-006 cycle_count_i  in  2  Decoded op length: 00 = 1 cycle, 01 = 2 cycles, 11 = 3 cycles.
REQ-007 mult_mode_i  in  2  Decoded mult_pext_mode_e (M8x8/M16x16/M32x16/M32x32).
REQ-008 accum_i  in  1  Decoded flag: the final cycle accumulates rd through the ALU.
REQ-009 imd_val_d_i  in  IMD_W  Partial product from the multiplier datapath.
REQ-010 mult_mode_o  out  2  Mode seen by the datapath; stable for the whole op.
REQ-011 stage_o  out  2  Current stage: 0, 1 or 2.
REQ-012 imd_we_o  out  1  Intermediate-register write strobe.
REQ-013 imd_val_q_o  out  IMD_W  Registered partial product.
REQ-014 accum_en_o  out  1  Selects ALU accumulation in the final cycle.
REQ-015 mult_valid_o  out  1  Result valid this cycle.
REQ-016 busy_o  out  1  High in any non-IDLE state.

Function
REQ-017 The FSM SHALL have states IDLE, S1 and S2; stage_o SHALL be 0 in IDLE, 1 in S1 and 2 in S2.
REQ-018 In IDLE with mult_en_i=1, mult_mode_o SHALL equal mult_mode_i combinationally.
REQ-019 In IDLE, the block SHALL latch cycle_count_i, mult_mode_i and accum_i on the accepting edge and drive them from the latches in S1 and S2; input changes after acceptance SHALL be ignored.
REQ-020 In IDLE with mult_en_i=1 and cycle_count_i=00, mult_valid_o SHALL be 1 in the same cycle and the state SHALL remain IDLE.
REQ-021 In IDLE with mult_en_i=1 and cycle_count_i=00, accum_en_o SHALL equal accum_i.
REQ-022 In IDLE with mult_en_i=1 and cycle_count_i!=00, imd_we_o SHALL be 1 and the next state SHALL be S1.
REQ-023 In S1 with latched count 01, mult_valid_o SHALL be 1, accum_en_o SHALL be the latched accum and the next state SHALL be IDLE.
REQ-024 In S1 with latched count 11, imd_we_o SHALL be 1 and the next state SHALL be S2.
REQ-025 In S2, mult_valid_o SHALL be 1, accum_en_o SHALL be the latched accum and the next state SHALL be IDLE.
REQ-026 imd_val_q_o SHALL load imd_val_d_i on each clock edge where imd_we_o=1 and otherwise hold.
REQ-027 Latency SHALL be 1, 2 or 3 cycles from acceptance to mult_valid_o for counts 00, 01 and 11 respectively.
REQ-028 mult_valid_o SHALL be a single-cycle pulse.
REQ-029 A back-to-back request in the cycle after mult_valid_o SHALL be accepted from IDLE with no bubble.
REQ-030 Flush: mult_en_i=0 in S1 or S2 SHALL force imd_we_o=0, mult_valid_o=0 and accum_en_o=0; the next state SHALL be IDLE and imd_val_q_o SHALL hold.
REQ-031 An illegal count of 10 SHALL be handled as 01 (2 cycles); the testbench SHALL flag it with an assertion.
REQ-032 With mult_en_i=0 in IDLE, all strobes SHALL be 0.

Reset
REQ-033 rst_i=1 SHALL force state IDLE, zero the latched count, mode and accum, and zero imd_val_q_o at the next edge.
REQ-034 rst_i SHALL have priority over every other input, including mid-op; no mult_valid_o SHALL follow a reset.
REQ-035 All outputs after reset SHALL be 0, except that mult_mode_o SHALL follow mult_mode_i only while mult_en_i=1.

Structure
REQ-036 The state typedef mult_pext_seq_state_e (IDLE, S1, S2) SHALL live in package ibex_pkg_pext beside mult_pext_mode_e.
REQ-037 The cycle-count encodings SHALL be named constants in ibex_pkg_pext.
REQ-038 The block SHALL be a single module with no sub-modules; the multiplier datapath and decode stay external.

Verification
REQ-039 The bench SHALL cover: count=00, en=1 -> valid in cycle 0, busy_o=0, imd_we_o never asserted.
REQ-040 The bench SHALL cover: count=11, accum=1, imd_val_d_i=0x1 then 0x2 -> imd_we_o in cycles 0 and 1, imd_val_q_o=0x2 at S2, valid with accum_en_o=1 in cycle 2.
REQ-041 The bench SHALL cover: count=01 accepted, then mode and count changed in S1 -> mult_mode_o unchanged, valid in cycle 1.
REQ-042 The bench SHALL cover: count=11, en dropped in S1 -> IDLE next cycle, no valid, imd_val_q_o holds the cycle-0 value.
REQ-043 The bench SHALL cover: rst_i=1 in S2 -> IDLE, imd_val_q_o=0, no valid pulse.
REQ-044 The bench SHALL cover: two count=01 ops back-to-back -> valid pulses in cycles 1 and 3, no idle cycle between ops.
